// File: rtl/fdivsqrt_intpostproc_pkg.sv
// -----------------------------------------------------------------------------
// fdivsqrt_intpostproc_pkg
//   Shared types for the integer post-processing back end of the divide/sqrt
//   unit: the configuration record (cvw_t) and the post-processor FSM state.
//   No ports; imported by fdivsqrt_intpostproc and its testbench.
// -----------------------------------------------------------------------------
package fdivsqrt_intpostproc_pkg;

  // Subset of the core configuration the integer back end depends on.
  //   XLEN    : integer register width (32 or 64)
  //   DIVb    : iterator fraction bits (must be >= XLEN)
  //   DIVBLEN : log2 width of the digit counts nM/mM (ports are DIVBLEN+1 wide)
  typedef struct packed {
    int unsigned XLEN;
    int unsigned DIVb;
    int unsigned DIVBLEN;
  } cvw_t;

  localparam cvw_t CVW_RV64_DEFAULT = '{XLEN: 64, DIVb: 64, DIVBLEN: 6};

  typedef enum logic [2:0] {
    PP_IDLE,
    PP_RESID,
    PP_SHIFT,
    PP_FIX,
    PP_HOLD
  } intpostproc_state_t;

endpackage

// File: rtl/fdivsqrt_intpostproc_intshift.sv
// -----------------------------------------------------------------------------
// fdivsqrt_intshift
//   Combinational dual right shifter that turns the fixed-point quotient and
//   remainder left by the iterator into integers. Each value is shifted right
//   by (DIVB - count); a count larger than DIVB would make that difference
//   negative, so the shift amount saturates at DIVB instead of wrapping.
// Ports
//   pre_q   [DIVB:0]    corrected quotient (fraction aligned)
//   pre_rem [DIVB+1:0]  corrected remainder (fraction aligned)
//   n_cnt   [NW-1:0]    quotient digit count
//   m_cnt   [NW-1:0]    divisor leading-zero count
//   int_q   [XLEN-1:0]  integer quotient magnitude
//   int_rem [XLEN-1:0]  integer remainder magnitude
// Requires DIVB >= XLEN.
// -----------------------------------------------------------------------------
module fdivsqrt_intshift #(
  parameter int XLEN = 64,
  parameter int DIVB = 64,
  parameter int NW   = 7
) (
  input  logic [DIVB:0]   pre_q,
  input  logic [DIVB+1:0] pre_rem,
  input  logic [NW-1:0]   n_cnt,
  input  logic [NW-1:0]   m_cnt,
  output logic [XLEN-1:0] int_q,
  output logic [XLEN-1:0] int_rem
);

  localparam logic [NW-1:0] DIVB_C = NW'(DIVB);

  function automatic logic [NW-1:0] sat_cnt(input logic [NW-1:0] digits);
    if (digits > DIVB_C) begin
      return DIVB_C;
    end
    return DIVB_C - digits;
  endfunction

  logic [DIVB:0]   q_sh;
  logic [DIVB+1:0] r_sh;
  logic            unused_hi;

  assign q_sh    = pre_q >> sat_cnt(n_cnt);
  assign r_sh    = pre_rem >> sat_cnt(m_cnt);
  assign int_q   = q_sh[XLEN-1:0];
  assign int_rem = r_sh[XLEN-1:0];

  // Bits above XLEN are always zero for a legal operation; drop them.
  assign unused_hi = ^{q_sh[DIVB:XLEN], r_sh[DIVB+1:XLEN]};

endmodule

// File: rtl/fdivsqrt_intpostproc.sv
// -----------------------------------------------------------------------------
// fdivsqrt_intpostproc
//   Integer back end of the divide/sqrt unit. On DoneIn it captures the
//   iterator's final quotient/residual and the preprocessing flags, then walks
//   IDLE -> RESID -> SHIFT -> FIX -> HOLD to produce the DIV/DIVU/REM/REMU(W)
//   result. Divide-by-zero and |A|<|B| skip straight to FIX.
// Ports
//   clk, reset (async, active low), FlushE (kill in-flight op)
//   DoneIn + WS/WC/D/U/UM/nM/mM + flag inputs : operation hand-off
//   ResultValid/ResultReady/IntDivResult       : result handshake
//   Busy                                       : op in flight
// -----------------------------------------------------------------------------
module fdivsqrt_intpostproc
  import fdivsqrt_intpostproc_pkg::*;
#(
  parameter cvw_t P = CVW_RV64_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                FlushE,
  input  logic                DoneIn,
  input  logic [P.DIVb+3:0]   WS,
  input  logic [P.DIVb+3:0]   WC,
  input  logic [P.DIVb+3:0]   D,
  input  logic [P.DIVb+1:0]   U,
  input  logic [P.DIVb+1:0]   UM,
  input  logic [P.DIVBLEN:0]  nM,
  input  logic [P.DIVBLEN:0]  mM,
  input  logic                NegQuotM,
  input  logic                AsM,
  input  logic                ALTBM,
  input  logic                BZeroM,
  input  logic                W64M,
  input  logic                RemOpM,
  input  logic [P.XLEN-1:0]   AM,
  input  logic                ResultReady,
  output logic                ResultValid,
  output logic [P.XLEN-1:0]   IntDivResult,
  output logic                Busy
);

  localparam int XLEN = int'(P.XLEN);
  localparam int DIVB = int'(P.DIVb);
  localparam int NW   = int'(P.DIVBLEN) + 1;
  localparam int RW   = DIVB + 4;

  intpostproc_state_t state_q, state_d;

  logic [RW-1:0]   ws_q, ws_d, wc_q, wc_d, dv_q, dv_d;
  logic [DIVB:0]   u_q, u_d, um_q, um_d;
  logic [NW-1:0]   nm_q, nm_d, mm_q, mm_d;
  logic            negquot_q, negquot_d, as_q, as_d;
  logic            altb_q, altb_d, bzero_q, bzero_d;
  logic            w64_q, w64_d, remop_q, remop_d;
  logic [XLEN-1:0] am_q, am_d;
  logic [DIVB:0]   preq_q, preq_d;
  logic [DIVB+1:0] prerem_q, prerem_d;
  logic [XLEN-1:0] intq_q, intq_d, intrem_q, intrem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;

  // Residual CPA and sign-based correction (RESID stage)
  logic [RW-1:0]   w_sum, w_fix;
  logic            w_neg;

  assign w_sum = ws_q + wc_q;
  assign w_neg = w_sum[RW-1];
  assign w_fix = w_sum + dv_q;

  // SHIFT stage
  logic [XLEN-1:0] sh_quot, sh_rem;

  fdivsqrt_intshift #(
    .XLEN (XLEN),
    .DIVB (DIVB),
    .NW   (NW)
  ) u_intshift (
    .pre_q   (preq_q),
    .pre_rem (prerem_q),
    .n_cnt   (nm_q),
    .m_cnt   (mm_q),
    .int_q   (sh_quot),
    .int_rem (sh_rem)
  );

  // FIX stage: special cases, sign restoration, result select
  logic [XLEN-1:0] q_fix, r_fix, sel, fix_result;

  always_comb begin
    if (bzero_q) begin
      q_fix = '1;
      r_fix = am_q;
    end else if (altb_q) begin
      q_fix = '0;
      r_fix = am_q;
    end else begin
      q_fix = negquot_q ? -intq_q : intq_q;
      r_fix = as_q ? -intrem_q : intrem_q;
    end
    sel = remop_q ? r_fix : q_fix;
  end

  generate
    if (XLEN > 32) begin : g_word_ext
      assign fix_result = w64_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end else begin : g_no_word
      logic unused_w64;
      assign unused_w64 = w64_q;
      assign fix_result = sel;
    end
  endgenerate

  // Quotient MSB and the residual bits above the remainder field never
  // reach the result once the residual sign has been taken.
  logic unused_bits;
  assign unused_bits = ^{U[DIVB+1], UM[DIVB+1], w_sum[RW-2:DIVB+2], w_fix[RW-1:DIVB+2]};

  always_comb begin
    state_d   = state_q;
    ws_d      = ws_q;
    wc_d      = wc_q;
    dv_d      = dv_q;
    u_d       = u_q;
    um_d      = um_q;
    nm_d      = nm_q;
    mm_d      = mm_q;
    negquot_d = negquot_q;
    as_d      = as_q;
    altb_d    = altb_q;
    bzero_d   = bzero_q;
    w64_d     = w64_q;
    remop_d   = remop_q;
    am_d      = am_q;
    preq_d    = preq_q;
    prerem_d  = prerem_q;
    intq_d    = intq_q;
    intrem_d  = intrem_q;
    result_d  = result_q;
    valid_d   = valid_q;

    case (state_q)
      PP_IDLE: begin
        // A flush in the same cycle as DoneIn discards the operation.
        if (DoneIn && !FlushE) begin
          ws_d      = WS;
          wc_d      = WC;
          dv_d      = D;
          u_d       = U[DIVB:0];
          um_d      = UM[DIVB:0];
          nm_d      = nM;
          mm_d      = mM;
          negquot_d = NegQuotM;
          as_d      = AsM;
          altb_d    = ALTBM;
          bzero_d   = BZeroM;
          w64_d     = W64M;
          remop_d   = RemOpM;
          am_d      = AM;
          state_d   = (BZeroM || ALTBM) ? PP_FIX : PP_RESID;
        end
      end
      PP_RESID: begin
        // Negative residual means the last quotient digit overshot by one.
        preq_d   = w_neg ? um_q : u_q;
        prerem_d = w_neg ? w_fix[DIVB+1:0] : w_sum[DIVB+1:0];
        state_d  = PP_SHIFT;
      end
      PP_SHIFT: begin
        intq_d   = sh_quot;
        intrem_d = sh_rem;
        state_d  = PP_FIX;
      end
      PP_FIX: begin
        result_d = fix_result;
        valid_d  = 1'b1;
        state_d  = PP_HOLD;
      end
      PP_HOLD: begin
        if (ResultReady) begin
          valid_d = 1'b0;
          state_d = PP_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = PP_IDLE;
      end
    endcase

    // Flush outranks everything, including a result being accepted; the
    // last delivered result stays on IntDivResult.
    if (FlushE && (state_q != PP_IDLE)) begin
      state_d  = PP_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PP_IDLE;
      ws_q      <= '0;
      wc_q      <= '0;
      dv_q      <= '0;
      u_q       <= '0;
      um_q      <= '0;
      nm_q      <= '0;
      mm_q      <= '0;
      negquot_q <= 1'b0;
      as_q      <= 1'b0;
      altb_q    <= 1'b0;
      bzero_q   <= 1'b0;
      w64_q     <= 1'b0;
      remop_q   <= 1'b0;
      am_q      <= '0;
      preq_q    <= '0;
      prerem_q  <= '0;
      intq_q    <= '0;
      intrem_q  <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ws_q      <= ws_d;
      wc_q      <= wc_d;
      dv_q      <= dv_d;
      u_q       <= u_d;
      um_q      <= um_d;
      nm_q      <= nm_d;
      mm_q      <= mm_d;
      negquot_q <= negquot_d;
      as_q      <= as_d;
      altb_q    <= altb_d;
      bzero_q   <= bzero_d;
      w64_q     <= w64_d;
      remop_q   <= remop_d;
      am_q      <= am_d;
      preq_q    <= preq_d;
      prerem_q  <= prerem_d;
      intq_q    <= intq_d;
      intrem_q  <= intrem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign ResultValid  = valid_q;
  assign IntDivResult = result_q;
  assign Busy         = (state_q != PP_IDLE);

endmodule

// File: tb/tb_fdivsqrt_intpostproc.sv
// -----------------------------------------------------------------------------
// tb_fdivsqrt_intpostproc
//   Drives DIV/REM operations into the integer post-processor. Iterator
//   outputs are synthesised from the true quotient/remainder of the operands;
//   expected results come from plain SystemVerilog division.
// -----------------------------------------------------------------------------
module tb_fdivsqrt_intpostproc;
  import fdivsqrt_intpostproc_pkg::*;

  localparam int XLEN = 64;
  localparam int DIVB = 64;
  localparam int RW   = DIVB + 4;
  localparam int QW   = DIVB + 2;
  localparam int NW   = 7;

  logic            clk = 1'b0;
  logic            reset, FlushE, DoneIn;
  logic [RW-1:0]   WS, WC, D;
  logic [QW-1:0]   U, UM;
  logic [NW-1:0]   nM, mM;
  logic            NegQuotM, AsM, ALTBM, BZeroM, W64M, RemOpM;
  logic [XLEN-1:0] AM;
  logic            ResultReady, ResultValid, Busy;
  logic [XLEN-1:0] IntDivResult;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fdivsqrt_intpostproc #(.P(CVW_RV64_DEFAULT)) dut (
    .clk          (clk),
    .reset        (reset),
    .FlushE       (FlushE),
    .DoneIn       (DoneIn),
    .WS           (WS),
    .WC           (WC),
    .D            (D),
    .U            (U),
    .UM           (UM),
    .nM           (nM),
    .mM           (mM),
    .NegQuotM     (NegQuotM),
    .AsM          (AsM),
    .ALTBM        (ALTBM),
    .BZeroM       (BZeroM),
    .W64M         (W64M),
    .RemOpM       (RemOpM),
    .AM           (AM),
    .ResultReady  (ResultReady),
    .ResultValid  (ResultValid),
    .IntDivResult (IntDivResult),
    .Busy         (Busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int bitlen(input logic [63:0] x);
    for (int i = 63; i >= 0; i--) begin
      if (x[i]) return i + 1;
    end
    return 0;
  endfunction

  // Architectural result of DIV/DIVU/REM/REMU and their W forms.
  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                             input bit rem, input bit sgn, input bit word);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    if (word) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0)
        r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
        r32 = rem ? 32'd0 : 32'h8000_0000;
      else if (sgn)
        r32 = rem ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else
        r32 = rem ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0)
      r64 = rem ? a : '1;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1)
      r64 = rem ? 64'd0 : 64'h8000_0000_0000_0000;
    else if (sgn)
      r64 = rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    else
      r64 = rem ? a % b : a / b;
    return r64;
  endfunction

  // Builds preprocessing flags and iterator outputs for an operation: the
  // quotient/remainder magnitudes are placed at a random fraction alignment,
  // and half the time the residual is left one divisor negative with U/UM
  // offset accordingly.
  task automatic load_op(input logic [63:0] a, input logic [63:0] b, input bit rem,
                         input bit sgn, input bit word, output int exp_lat);
    logic [63:0] ea, eb, ma, mb, q, r;
    logic [95:0] rnd;
    logic [RW-1:0] wv;
    bit sa, sb;
    int nmin, mmin, sq, sm;
    ea = word ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    eb = word ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    sa = sgn && ea[63];
    sb = sgn && eb[63];
    ma = sa ? -ea : ea;
    mb = sb ? -eb : eb;
    AM       = ea;
    BZeroM   = (mb == 64'd0);
    ALTBM    = (mb == 64'd0) ? 1'($urandom_range(0, 1)) : (ma < mb);
    NegQuotM = sa ^ sb;
    AsM      = sa;
    W64M     = word;
    RemOpM   = rem;
    exp_lat  = (mb == 64'd0 || ma < mb) ? 2 : 4;
    if (mb == 64'd0) begin
      q = 64'd0;
      r = 64'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    nmin = (bitlen(q) > 0) ? bitlen(q) - 1 : 0;
    mmin = (bitlen(mb) > 0) ? bitlen(mb) - 1 : 0;
    nM = NW'($urandom_range(DIVB, nmin));
    mM = NW'($urandom_range(DIVB, mmin));
    sq = DIVB - int'(nM);
    sm = DIVB - int'(mM);
    D  = RW'(mb) << sm;
    if ($urandom_range(0, 1) == 1) begin
      U  = (QW'(q) + QW'(1)) << sq;
      UM = QW'(q) << sq;
      wv = (RW'(r) - RW'(mb)) << sm;
    end else begin
      U  = QW'(q) << sq;
      UM = (QW'(q) - QW'(1)) << sq;
      wv = RW'(r) << sm;
    end
    rnd = {$urandom(), $urandom(), $urandom()};
    WS  = rnd[RW-1:0];
    WC  = wv - WS;
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input bit rem, input bit sgn, input bit word,
                        input logic [63:0] exp, input int hold);
    int exp_lat, lat;
    bit seen;
    load_op(a, b, rem, sgn, word, exp_lat);
    DoneIn = 1'b1;
    @(negedge clk);
    DoneIn = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (lat <= 20) begin
      if (ResultValid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no ResultValid within 20 cycles, want latency %0d", tag, exp_lat);
      return;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, IntDivResult, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 64'(ResultValid), 64'd1);
      chk({tag, " hold result"}, IntDivResult, exp);
    end
    ResultReady = 1'b1;
    @(negedge clk);
    ResultReady = 1'b0;
    chk({tag, " valid after ready"}, 64'(ResultValid), 64'd0);
    chk({tag, " busy after ready"}, 64'(Busy), 64'd0);
    $display("op %s a=%h b=%h rem=%0d sgn=%0d w=%0d -> %h (want %h) lat=%0d",
             tag, a, b, rem, sgn, word, IntDivResult, exp, lat);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    bit          rem;
    bit          sgn;
    bit          word;
    logic [63:0] exp;
    int          hold;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  initial begin
    int exp_lat;
    bit any_valid;
    logic [63:0] ra, rb, rexp;
    bit rrem, rsgn, rword;

    vecs[0]  = '{64'd20, 64'd3, 1'b0, 1'b0, 1'b0, 64'd6, 0};
    vecs[1]  = '{-64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5};
    vecs[2]  = '{-64'sd7, 64'd2, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 0};
    vecs[3]  = '{64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[4]  = '{64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 64'd5, 0};
    vecs[5]  = '{64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 0};
    vecs[6]  = '{64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 64'd0, 0};
    vecs[7]  = '{64'd3, 64'd10, 1'b0, 1'b0, 1'b0, 64'd0, 0};
    vecs[8]  = '{64'd3, 64'd10, 1'b1, 1'b0, 1'b0, 64'd3, 0};
    vecs[9]  = '{64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[10] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0,
                 64'h8000_0000_0000_0000, 0};
    vecs[11] = '{-64'sd9, -64'sd4, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[13] = '{64'd1000003, 64'd97, 1'b1, 1'b0, 1'b0, 64'd1000003 % 64'd97, 0};

    FlushE = 1'b0; DoneIn = 1'b0; ResultReady = 1'b0;
    WS = '0; WC = '0; D = '0; U = '0; UM = '0; nM = '0; mM = '0;
    NegQuotM = 1'b0; AsM = 1'b0; ALTBM = 1'b0; BZeroM = 1'b0; W64M = 1'b0; RemOpM = 1'b0;
    AM = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #10;
    chk("reset valid", 64'(ResultValid), 64'd0);
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset result", IntDivResult, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].rem, vecs[i].sgn,
             vecs[i].word, vecs[i].exp, vecs[i].hold);
    end

    // Async reset while in SHIFT
    load_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, exp_lat);
    DoneIn = 1'b1;
    @(negedge clk);
    DoneIn = 1'b0;
    @(negedge clk);
    chk("busy before reset", 64'(Busy), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("midop reset valid", 64'(ResultValid), 64'd0);
    chk("midop reset busy", 64'(Busy), 64'd0);
    chk("midop reset result", IntDivResult, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    $display("op reset-in-SHIFT done");

    // Flush in RESID, then an op right behind it
    run_op("pre-flush", 64'd77, 64'd5, 1'b0, 1'b0, 1'b0, 64'd15, 0);
    load_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, exp_lat);
    DoneIn = 1'b1;
    @(negedge clk);
    DoneIn = 1'b0;
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    chk("flush resid busy", 64'(Busy), 64'd0);
    any_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ResultValid) any_valid = 1'b1;
      @(negedge clk);
    end
    chk("flush resid no valid", 64'(any_valid), 64'd0);
    chk("flush resid result kept", IntDivResult, 64'd15);
    $display("op flush-in-RESID done");
    run_op("after-flush", 64'd100, 64'd7, 1'b1, 1'b0, 1'b0, 64'd2, 0);

    // FlushE together with DoneIn in IDLE: nothing captured
    load_op(64'd50, 64'd5, 1'b0, 1'b0, 1'b0, exp_lat);
    DoneIn = 1'b1;
    FlushE = 1'b1;
    @(negedge clk);
    DoneIn = 1'b0;
    FlushE = 1'b0;
    chk("flush+done busy", 64'(Busy), 64'd0);
    any_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (ResultValid) any_valid = 1'b1;
      @(negedge clk);
    end
    chk("flush+done no valid", 64'(any_valid), 64'd0);
    $display("op flush-with-done done");

    // Flush in HOLD with ResultReady also high: result stays, valid drops
    load_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, exp_lat);
    DoneIn = 1'b1;
    @(negedge clk);
    DoneIn = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold valid before flush", 64'(ResultValid), 64'd1);
    FlushE = 1'b1;
    ResultReady = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    ResultReady = 1'b0;
    chk("flush hold valid", 64'(ResultValid), 64'd0);
    chk("flush hold busy", 64'(Busy), 64'd0);
    chk("flush hold result", IntDivResult, 64'd14);
    $display("op flush-in-HOLD done");

    // Randomized operations, back to back
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = 64'($urandom_range(0, 200)); rb = 64'($urandom_range(0, 20)); end
        1: begin ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()}; end
        2: begin ra = {$urandom(), $urandom()}; rb = 64'($urandom_range(1, 1000)); end
        default: begin
          ra = {$urandom(), $urandom()};
          rb = {$urandom(), $urandom()} >> $urandom_range(8, 63);
        end
      endcase
      rrem  = 1'($urandom_range(0, 1));
      rsgn  = 1'($urandom_range(0, 1));
      rword = 1'($urandom_range(0, 1));
      rexp  = ref_result(ra, rb, rrem, rsgn, rword);
      run_op($sformatf("rnd%0d", n), ra, rb, rrem, rsgn, rword, rexp, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation still running at 200000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
